// File: rtl/multicycle_controller.sv
// Control unit for the multicycle ARM-subset datapath: 10-state sequencer,
// instruction-field decode, ALU decode and conditional-execution logic.
module multicycle_controller (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cond,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic [3:0] rd,
    input  logic [3:0] alu_flags,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_control,
    output logic [1:0] imm_src,
    output logic [1:0] reg_src
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
        S_MEMWRITE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH
    } state_t;

    state_t     state, next_state, cur_state;
    logic [3:0] flags;
    logic       next_pc, reg_w, mem_w, branch, alu_op;
    logic [1:0] flag_w;
    logic       cond_ex, pcs, is_cmp, rd_is_pc;
    logic       n_f, z_f, c_f, v_f;

    assign {n_f, z_f, c_f, v_f} = flags;
    assign is_cmp   = (op == 2'b00) && (funct[4:1] == 4'b1010);
    assign rd_is_pc = (rd == 4'hF);

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        imm_src    = (op == 2'b11) ? 2'b00 : op;
        reg_src[0] = (op == 2'b10);
        reg_src[1] = (op == 2'b01);
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = z_f;
            4'b0001: cond_ex = ~z_f;
            4'b0010: cond_ex = c_f;
            4'b0011: cond_ex = ~c_f;
            4'b0100: cond_ex = n_f;
            4'b0101: cond_ex = ~n_f;
            4'b0110: cond_ex = v_f;
            4'b0111: cond_ex = ~v_f;
            4'b1000: cond_ex = c_f & ~z_f;
            4'b1001: cond_ex = ~c_f | z_f;
            4'b1010: cond_ex = (n_f == v_f);
            4'b1011: cond_ex = (n_f != v_f);
            4'b1100: cond_ex = ~z_f & (n_f == v_f);
            4'b1101: cond_ex = z_f | (n_f != v_f);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // While reset is held the outputs look like FETCH, so decode from FETCH
    // rather than whatever state the register happens to hold.
    always_comb begin
        cur_state  = rst ? S_FETCH : state;
        next_state = S_FETCH;
        next_pc    = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        alu_op     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        case (cur_state)
            S_FETCH: begin
                ir_write   = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                next_pc    = 1'b1;
                next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b01:   next_state = S_MEMADR;
                    2'b00:   next_state = funct[5] ? S_EXEC_I : S_EXEC_R;
                    2'b10:   next_state = S_BRANCH;
                    default: next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_b  = 2'b01;
                next_state = funct[0] ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src    = 1'b1;
                next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXEC_R: begin
                alu_op     = 1'b1;
                next_state = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_b  = 2'b01;
                alu_op     = 1'b1;
                next_state = S_ALUWB;
            end
            S_ALUWB: reg_w = 1'b1;
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                branch     = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
        if (rst) begin
            next_state = S_FETCH;
            next_pc    = 1'b0;
            ir_write   = 1'b0;
        end
    end

    // ALU decode; CMP is a SUB that always sets all four flags.
    always_comb begin
        alu_control = 2'b00;
        flag_w      = 2'b00;
        if (alu_op) begin
            case (funct[4:1])
                4'b0100: alu_control = 2'b00;
                4'b0010: alu_control = 2'b01;
                4'b0000: alu_control = 2'b10;
                4'b1100: alu_control = 2'b11;
                4'b1010: alu_control = 2'b01;
                default: alu_control = 2'b00;
            endcase
            flag_w[1] = funct[0] | (funct[4:1] == 4'b1010);
            flag_w[0] = flag_w[1] & ((funct[4:1] == 4'b0100) |
                                     (funct[4:1] == 4'b0010) |
                                     (funct[4:1] == 4'b1010));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'b0000;
        end else begin
            if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
        end
    end

    assign pcs       = (rd_is_pc & reg_w) | branch;
    assign pc_write  = next_pc | (pcs & cond_ex);
    assign reg_write = reg_w & cond_ex & ~rd_is_pc & ~is_cmp;
    assign mem_write = mem_w & cond_ex;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: a per-instruction
// reference model queues expected control vectors, a monitor compares them.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_control;
        logic [1:0] imm_src;
        logic [1:0] reg_src;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cond, rd, alu_flags;
    logic [1:0] op;
    logic [5:0] funct;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] result_src, alu_src_b, alu_control, imm_src, reg_src;

    ctrl_t      act_vec;
    ctrl_t      exp_q[$];
    string      tag_q[$];
    logic [3:0] model_flags;
    int         n_compared = 0;
    int         n_mismatched = 0;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .pc_write(pc_write), .adr_src(adr_src),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_control(alu_control), .imm_src(imm_src), .reg_src(reg_src)
    );

    always #5 clk = ~clk;

    assign act_vec = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                      alu_src_a, alu_src_b, alu_control, imm_src, reg_src};

    function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] alu_code(input logic [3:0] cmd);
        case (cmd)
            4'b0010, 4'b1010: return 2'b01;
            4'b0000:          return 2'b10;
            4'b1100:          return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input ctrl_t act, input ctrl_t exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(tag_q.pop_front(), act_vec, exp_q.pop_front());
    end

    task automatic push_exp(input ctrl_t v, input string tag);
        exp_q.push_back(v);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: walks one instruction cycle by cycle and
    // predicts every control output. abort_at names a cycle in which reset is pulsed.
    task automatic applyStimulus(input logic [3:0] c, input logic [1:0] o, input logic [5:0] fn,
                                 input logic [3:0] r, input logic [3:0] ex_flags,
                                 input int abort_at, input string name);
        int    n_cyc;
        ctrl_t v;
        logic  ex, cmp;
        logic [3:0] af;
        n_cyc = (o == 2'b00) ? 4 : (o == 2'b01) ? (fn[0] ? 5 : 4) : (o == 2'b10) ? 3 : 2;
        cmp = (o == 2'b00) && (fn[4:1] == 4'b1010);
        for (int k = 0; k < n_cyc; k++) begin
            af = (o == 2'b00 && k == 2) ? ex_flags : 4'($urandom);
            cond = c; op = o; funct = fn; rd = r; alu_flags = af;
            v = '0;
            v.imm_src = (o == 2'b11) ? 2'b00 : o;
            v.reg_src = {o == 2'b01, o == 2'b10};
            if (k == abort_at) begin
                rst = 1'b1;
                v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.result_src = 2'b10;
                model_flags = 4'b0000;
                push_exp(v, $sformatf("%s rst c%0d", name, k));
                rst = 1'b0;
                return;
            end
            rst = 1'b0;
            ex = cond_holds(c, model_flags);
            if (k == 0) begin
                v.pc_write = 1'b1; v.ir_write = 1'b1;
                v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.result_src = 2'b10;
            end else if (k == 1) begin
                v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.result_src = 2'b10;
            end else if (o == 2'b00) begin
                if (k == 2) begin
                    v.alu_src_b = fn[5] ? 2'b01 : 2'b00;
                    v.alu_control = alu_code(fn[4:1]);
                end else begin
                    v.reg_write = ex && r != 4'hF && !cmp;
                    v.pc_write  = ex && r == 4'hF;
                end
            end else if (o == 2'b01) begin
                if (k == 2) v.alu_src_b = 2'b01;
                else if (k == 3) begin
                    v.adr_src = 1'b1;
                    v.mem_write = !fn[0] && ex;
                end else begin
                    v.result_src = 2'b01;
                    v.reg_write = ex && r != 4'hF;
                    v.pc_write  = ex && r == 4'hF;
                end
            end else begin
                v.alu_src_b = 2'b01; v.result_src = 2'b10; v.pc_write = ex;
            end
            // Flags are captured at the end of the execute cycle.
            if (o == 2'b00 && k == 2 && ex && (fn[0] || cmp)) begin
                model_flags[3:2] = af[3:2];
                if (fn[4:1] == 4'b0100 || fn[4:1] == 4'b0010 || cmp) model_flags[1:0] = af[1:0];
            end
            push_exp(v, $sformatf("%s c%0d", name, k));
        end
    endtask

    initial begin
        ctrl_t rv;
        rst = 1'b1; cond = 4'hE; op = 2'b01; funct = 6'b011001; rd = 4'd2; alu_flags = 4'b0;
        model_flags = 4'b0000;
        @(posedge clk);
        #1;
        rv = '0;
        rv.alu_src_a = 1'b1; rv.alu_src_b = 2'b10; rv.result_src = 2'b10;
        rv.imm_src = 2'b01; rv.reg_src = 2'b10;
        for (int i = 0; i < 3; i++) push_exp(rv, $sformatf("reset hold %0d", i));

        applyStimulus(4'hD, 2'b01, 6'b011000, 4'd3, 4'b0000, -1, "STR LE fails");
        applyStimulus(4'hE, 2'b00, 6'b101001, 4'd1, 4'b0100, -1, "ADDS imm");
        applyStimulus(4'hD, 2'b01, 6'b011000, 4'd3, 4'b0000, -1, "STR LE passes");
        applyStimulus(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, -1, "CMP");
        applyStimulus(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, -1, "BEQ taken");
        applyStimulus(4'h1, 2'b10, 6'b100000, 4'd0, 4'b0000, -1, "BNE not taken");
        applyStimulus(4'hE, 2'b01, 6'b011001, 4'd4, 4'b0000, -1, "LDR");
        applyStimulus(4'hE, 2'b00, 6'b000100, 4'hF, 4'b0000, -1, "SUB pc");
        applyStimulus(4'hE, 2'b00, 6'b000101, 4'hF, 4'b0100, 2, "SUBS reset in exec");
        applyStimulus(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, -1, "BEQ after reset");
        applyStimulus(4'hE, 2'b11, 6'b000000, 4'd0, 4'b0000, -1, "NOP");

        for (int i = 0; i < 200; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
            applyStimulus(4'($urandom), 2'($urandom), 6'($urandom), r, 4'($urandom),
                          ($urandom_range(0, 24) == 0) ? $urandom_range(0, 4) : -1,
                          $sformatf("rand%0d", i));
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle ARM-subset datapath: a 10-state FSM plus condition/flag logic that sequences fetch, decode, execute, memory and writeback for every instruction. It sits in the decode path, reading the instruction-register fields. It drives the datapath muxes and enables, including `imm_src`, which selects the immediate-extend format (00 DP rotated imm8, 01 12-bit memory offset, 10 branch 24-bit <<2).

## Interface
No parameters.
- `clk` in 1: rising-edge system clock.
- `rst` in 1: synchronous reset, active-high.
- `cond` in 4: instr[31:28].
- `op` in 2: instr[27:26].
- `funct` in 6: instr[25:20]; [5]=I, [4:1]=cmd, [0]=S/L.
- `rd` in 4: instr[15:12].
- `alu_flags` in 4: {N,Z,C,V} from the ALU, current cycle.
- `pc_write` out 1: PC register enable.
- `adr_src` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `mem_write` out 1: data memory write enable.
- `ir_write` out 1: instruction register enable.
- `reg_write` out 1: register file write enable.
- `result_src` out 2: result select; 00 ALUOut, 01 Data, 10 ALU result.
- `alu_src_a` out 1: ALU A select; 0 = register A, 1 = PC.
- `alu_src_b` out 2: ALU B select; 00 register B, 01 ExtImm, 10 constant 4.
- `alu_control` out 2: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- `imm_src` out 2: extend format select.
- `reg_src` out 2: [0] read R15 as Rn, [1] read Rd as Rm.

## Operation
Combinational decode from instruction fields:
- `imm_src` = `op` for op∈{00,01,10}; op=11 → 00.
- `reg_src[0]` = (op==10); `reg_src[1]` = (op==01).
- `alu_op` is internal. When 0 → ADD. When 1, decode `funct[4:1]`:
  - 0100 ADD → 00.
  - 0010 SUB → 01.
  - 0000 AND → 10.
  - 1100 ORR → 11.
  - 1010 CMP → 01, with register write suppressed.
  - Any other cmd → ADD.
- Flag write (only when `alu_op`=1 and `funct[0]`=1):
  - `flag_w[1]` updates N,Z.
  - `flag_w[0]` updates C,V, for ADD/SUB/CMP only.
  - CMP always writes flags.

Condition logic:
- 4-bit flags register, reset 0000.
- `cond_ex` is evaluated combinationally from `cond` against the stored flags, using the standard ARM table (EQ…LE): 1110 AL = 1; 1111 = 0.
- `pcs` = (rd==15 & internal reg_w) | branch.
- `pc_write` = next_pc | (pcs & `cond_ex`).
- `reg_write` = reg_w & `cond_ex` & ¬(rd==15) & ¬CMP.
- `mem_write` = mem_w & `cond_ex`.
- Flag enables are ANDed with `cond_ex`.

FSM states. Outputs not listed are 0 / 00.
- FETCH: `adr_src`=0, `ir_write`=1, `alu_src_a`=1, `alu_src_b`=10, `result_src`=10, next_pc=1. → DECODE.
- DECODE: `alu_src_a`=1, `alu_src_b`=10, `result_src`=10 (forms PC+8). Next state:
  - op=01 → MEMADR.
  - op=00 & funct[5]=0 → EXEC_R.
  - op=00 & funct[5]=1 → EXEC_I.
  - op=10 → BRANCH.
  - op=11 → FETCH (NOP).
- MEMADR: `alu_src_b`=01. funct[0]=1 → MEMREAD, else → MEMWRITE.
- MEMREAD: `adr_src`=1. → MEMWB.
- MEMWB: `result_src`=01, reg_w. → FETCH.
- MEMWRITE: `adr_src`=1, mem_w. → FETCH.
- EXEC_R: `alu_op`=1. → ALUWB.
- EXEC_I: `alu_src_b`=01, `alu_op`=1; flags latch at end of this cycle. → ALUWB.
- ALUWB: reg_w. → FETCH.
- BRANCH: `alu_src_b`=01, `result_src`=10, branch=1. → FETCH.

EXEC_R also latches flags at end of cycle.

## Timing
- Reset: state=FETCH, flags=0000.
  - While `rst`=1: `pc_write`, `ir_write`, `reg_write` and `mem_write` are forced 0. Other outputs show FETCH values.
  - First FETCH executes in the cycle after `rst` falls.
- Reset asserted mid-instruction: the next state is FETCH and no write enable fires that cycle.
- Latencies, in cycles FETCH→FETCH: B = 3, DP = 4, STR = 4, LDR = 5.
- Flags update at the end of EXEC_*. A following instruction sees them in its own cycles.
- A failed condition still walks the full state path, with all writes suppressed.
- `rd`=15 writeback: `pc_write`=1 in ALUWB/MEMWB; `reg_write`=0.

## Test plan
- Reset: hold `rst` 3 cycles → all write enables 0. Release → `ir_write`=1 and `pc_write`=1 in the first cycle, state DECODE next.
- ADDS R1,R2,#5 (op=00, funct=101001, cond=1110) → states FETCH,DECODE,EXEC_I,ALUWB.
  - `imm_src`=00, `alu_control`=00, `reg_write`=1 in ALUWB.
  - `alu_flags`=0100 during EXEC_I is latched (Z=1).
- Conditional branch:
  - CMP with `alu_flags`=0100, then BEQ (op=10, cond=0000) → `pc_write`=1 in BRANCH, `imm_src`=10, `reg_src[0]`=1.
  - BNE (cond=0001) under the same flags → `pc_write`=0.
- LDR (op=01, funct=011001) → 5 cycles. `adr_src`=1 in MEMREAD, `result_src`=01 and `reg_write`=1 in MEMWB, `imm_src`=01.
- STR with cond=1101 (LE) and flags 0000 → `mem_write`=0 in MEMWRITE. Same instruction with flags 0100 → `mem_write`=1, `reg_src[1]`=1.
- SUB with `rd`=15 → `pc_write`=1 and `reg_write`=0 in ALUWB. Asserting `rst` during EXEC_R → FETCH next cycle, flags 0000.
